// File: rtl/scan_chain_ctrl.sv
// scan_chain_ctrl: loads a pattern into a scan chain, captures once, unloads and compares against a golden response.
module scan_chain_ctrl #(
  parameter int CHAIN_LEN = 8,
  parameter int CNT_W     = 7
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 start,
  input  logic                 abort,
  input  logic [CHAIN_LEN-1:0] pattern,
  input  logic [CHAIN_LEN-1:0] expected,
  output logic                 SE,
  output logic                 SD,
  input  logic                 SO,
  output logic [CHAIN_LEN-1:0] response,
  output logic                 busy,
  output logic                 done,
  output logic                 pass
);
  typedef enum logic [2:0] {IDLE, SHIFT_IN, CAPTURE, SHIFT_OUT, DONE} state_t;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(CHAIN_LEN - 1);
  state_t               state, state_n;
  logic [CNT_W-1:0]     cnt, cnt_n;
  logic [CHAIN_LEN-1:0] pat_sh, exp_r, shift_r, shift_n;
  logic                 se_n, sd_n, last;
  assign last    = cnt == LAST;
  assign shift_n = {shift_r[CHAIN_LEN-2:0], SO};
  assign busy    = state inside {SHIFT_IN, CAPTURE, SHIFT_OUT};
  assign done    = state == DONE;
  always_comb begin
    state_n = state;
    cnt_n   = '0;
    se_n    = 1'b0;
    sd_n    = 1'b0;
    if (abort) state_n = IDLE;
    else unique case (state)
      IDLE: if (start) begin
        state_n = SHIFT_IN;
        se_n    = 1'b1;
        sd_n    = pattern[CHAIN_LEN-1];
      end
      SHIFT_IN: if (last) state_n = CAPTURE;
      else begin
        cnt_n = cnt + CNT_W'(1);
        se_n  = 1'b1;
        sd_n  = pat_sh[CHAIN_LEN-1];
      end
      CAPTURE: begin
        state_n = SHIFT_OUT;
        se_n    = 1'b1;
      end
      SHIFT_OUT: if (last) state_n = DONE;
      else begin
        cnt_n = cnt + CNT_W'(1);
        se_n  = 1'b1;
      end
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end
  // SE/SD are registered from next-state values so they switch on the same edge as the state
  always_ff @(posedge CLK) begin
    if (RST) begin
      state    <= IDLE;
      cnt      <= '0;
      SE       <= 1'b0;
      SD       <= 1'b0;
      pass     <= 1'b0;
      response <= '0;
      pat_sh   <= '0;
      exp_r    <= '0;
      shift_r  <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      SE    <= se_n;
      SD    <= sd_n;
      if (state == IDLE && start && !abort) begin
        pat_sh <= pattern << 1;
        exp_r  <= expected;
      end else if (state == SHIFT_IN) pat_sh <= pat_sh << 1;
      // unload into a shadow register so an aborted run leaves response untouched
      if (state == SHIFT_OUT && !abort) begin
        shift_r <= shift_n;
        if (last) begin
          response <= shift_n;
          pass     <= shift_n == exp_r;
        end
      end
    end
  end
endmodule

// File: tb/tb_scan_chain_ctrl.sv
// tb_scan_chain_ctrl: drives a behavioural 8-flop scan chain (D = ~Q) and checks runs against a spec-level model.
module tb_scan_chain_ctrl;
  localparam int N = 8;
  logic         CLK = 1'b0, RST = 1'b1, start = 1'b0, abort = 1'b0;
  logic [N-1:0] pattern = '0, expected = '0, response, q;
  logic         SE, SD, SO, busy, done, pass;
  logic [N-1:0] m_resp = '0;
  logic         m_pass = 1'b0;
  int           checks = 0, errors = 0;

  always #5 CLK = ~CLK;
  always @(posedge CLK) q <= SE ? {q[N-2:0], SD} : ~q;
  assign SO = q[N-1];

  scan_chain_ctrl #(.CHAIN_LEN(N), .CNT_W(7)) dut (
    .CLK(CLK), .RST(RST), .start(start), .abort(abort), .pattern(pattern),
    .expected(expected), .SE(SE), .SD(SD), .SO(SO), .response(response),
    .busy(busy), .done(done), .pass(pass)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_se"}, 32'(SE), 32'(0));
    chk({tag, "_sd"}, 32'(SD), 32'(0));
    chk({tag, "_busy"}, 32'(busy), 32'(0));
    chk({tag, "_done"}, 32'(done), 32'(0));
  endtask

  // Starts at a negedge in IDLE; returns at the negedge of the DONE cycle, or after an abort/reset cut.
  task automatic run(input logic [N-1:0] p, input logic [N-1:0] e, input bit hold,
                     input int cut, input bit by_rst);
    pattern = p;
    expected = e;
    start = 1'b1;
    for (int c = 1; c <= 2 * N + 2; c++) begin
      @(negedge CLK);
      if (!hold) start = 1'b0;
      pattern = N'($urandom);
      expected = N'($urandom);
      chk("se", 32'(SE), 32'(c <= N || (c >= N + 2 && c <= 2 * N + 1)));
      chk("sd", 32'(SD), 32'(c <= N ? p[N-c] : 1'b0));
      chk("busy", 32'(busy), 32'(c <= 2 * N + 1));
      chk("done", 32'(done), 32'(c == 2 * N + 2));
      if (c == cut) begin
        if (by_rst) RST = 1'b1; else abort = 1'b1;
        @(negedge CLK);
        RST = 1'b0;
        abort = 1'b0;
        if (by_rst) begin
          m_resp = '0;
          m_pass = 1'b0;
        end
        chk_idle("cut");
        chk("cut_resp", 32'(response), 32'(m_resp));
        chk("cut_pass", 32'(pass), 32'(m_pass));
        for (int i = 0; i < N + 4; i++) begin
          @(negedge CLK);
          chk("cut_nodone", 32'(done), 32'(0));
        end
        chk("cut_resp_hold", 32'(response), 32'(m_resp));
        return;
      end
    end
    m_resp = ~p;
    m_pass = (~p == e);
    chk("resp", 32'(response), 32'(m_resp));
    chk("pass", 32'(pass), 32'(m_pass));
  endtask

  initial begin
    logic [N-1:0] rp;
    repeat (2) @(negedge CLK);
    chk_idle("rst");
    chk("rst_resp", 32'(response), 32'(0));
    chk("rst_pass", 32'(pass), 32'(0));
    RST = 1'b0;
    @(negedge CLK);
    start = 1'b1;
    abort = 1'b1;
    @(negedge CLK);
    start = 1'b0;
    abort = 1'b0;
    chk_idle("start_abort");
    @(negedge CLK);
    chk_idle("start_abort2");
    run(8'hA5, 8'h5A, 1'b0, 0, 1'b0);
    @(negedge CLK);
    run(8'h3C, 8'hFF, 1'b0, 0, 1'b0);
    @(negedge CLK);
    run(8'h96, 8'h69, 1'b0, N + 5, 1'b0);
    @(negedge CLK);
    run(8'h0F, 8'hF0, 1'b0, N + 1, 1'b1);
    @(negedge CLK);
    run(8'hFF, 8'h00, 1'b0, 0, 1'b0);
    @(negedge CLK);
    for (int r = 0; r < 3; r++) begin
      run(N'($urandom), N'($urandom), 1'b1, 0, 1'b0);
      @(negedge CLK);
      chk_idle("b2b_gap");
    end
    start = 1'b0;
    @(negedge CLK);
    chk_idle("b2b_end");
    for (int r = 0; r < 6; r++) begin
      rp = N'($urandom);
      run(rp, ($urandom % 2) ? ~rp : N'($urandom), 1'b0, 0, 1'b0);
      @(negedge CLK);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/scan_chain_ctrl.md
SCAN_CHAIN_CTRL -- requirements
Module: scan_chain_ctrl

Interface
REQ-001 SHALL have parameter CHAIN_LEN, default 8, giving the number of scan flops in the driven chain (legal range 2..64).
REQ-002 SHALL have parameter CNT_W, default 7, giving the shift-counter width (must satisfy 2**CNT_W > CHAIN_LEN).
REQ-003 SHALL have port CLK  input  1  single clock; all state updates on the rising edge.
REQ-004 SHALL have port RST  input  1  reset, synchronous and active-high.
REQ-005 SHALL have port start  input  1  request one test run; sampled only in IDLE.
REQ-006 SHALL have port abort  input  1  terminate the run in progress.
REQ-007 SHALL have port pattern  input  CHAIN_LEN  stimulus; bit i is loaded into chain flop i.
REQ-008 SHALL have port expected  input  CHAIN_LEN  golden response; bit i is compared with captured flop i.
REQ-009 SHALL have port SE  output  1  scan enable to the chain (registered).
REQ-010 SHALL have port SD  output  1  serial scan data into chain flop 0 (registered).
REQ-011 SHALL have port SO  input  1  serial scan data out of chain flop CHAIN_LEN-1.
REQ-012 SHALL have port response  output  CHAIN_LEN  unloaded chain contents; bit i = flop i.
REQ-013 SHALL have port busy  output  1  high while a run is in progress.
REQ-014 SHALL have port done  output  1  one-cycle pulse at run completion.
REQ-015 SHALL have port pass  output  1  result of the last completed run (response == expected).

Function
REQ-016 SHALL implement the FSM IDLE -> SHIFT_IN -> CAPTURE -> SHIFT_OUT -> DONE -> IDLE.
REQ-017 IDLE: SE=0, SD=0, busy=0; on start=1 SHALL latch pattern and expected and enter SHIFT_IN on the next edge.
REQ-018 SHIFT_IN: SHALL last exactly CHAIN_LEN cycles with SE=1; on shift cycle k (k=0..CHAIN_LEN-1), SD = pattern[CHAIN_LEN-1-k], so that flop i holds pattern[i] after the last shift edge.
REQ-019 CAPTURE: SHALL last exactly 1 cycle with SE=0 and SD=0, so the chain loads its functional D inputs.
REQ-020 SHIFT_OUT: SHALL last exactly CHAIN_LEN cycles with SE=1 and SD=0; on the edge ending cycle k, SO SHALL be sampled into response[CHAIN_LEN-1-k].
REQ-021 DONE: SHALL last 1 cycle with done=1, busy=0, SE=0; pass SHALL be updated to (response == expected) on the DONE entry edge; the next state SHALL be IDLE.
REQ-022 Latency: with start sampled at edge E0, SE SHALL rise at E0, done SHALL be high in cycle 2*CHAIN_LEN+2, and the next start SHALL be accepted one cycle later.
REQ-023 busy SHALL be 1 exactly in SHIFT_IN, CAPTURE and SHIFT_OUT.
REQ-024 start while not in IDLE SHALL be ignored; latched pattern and expected SHALL NOT change mid-run.
REQ-025 abort=1 in any non-IDLE state SHALL force IDLE on the next edge with SE=0 and SD=0; done SHALL NOT pulse, and pass and response SHALL keep their prior values.
REQ-026 Simultaneous start and abort in IDLE: abort SHALL win and no run starts.
REQ-027 The shift counter SHALL count 0..CHAIN_LEN-1, reset to 0 on every state change, and never wrap inside a state.
REQ-028 response SHALL hold its value between runs and SHALL only be written in SHIFT_OUT.

Reset
REQ-029 RST=1 at a rising edge SHALL force IDLE and set SE=0, SD=0, busy=0, done=0, pass=0, response=0 and counter=0, regardless of state.
REQ-030 Reset asserted mid-run SHALL take priority over abort, start and FSM progress; no done pulse SHALL follow.

Verification
REQ-031 The bench SHALL drive a chain of 8 behavioural scan flops (SE ? SD : D), CHAIN_LEN=8, with functional D inputs tied so that D_i = ~Q_i.
REQ-032 Scenario 1: pattern=8'hA5, expected=8'h5A, pulse start -> SE high for 8 cycles, low for 1, then high for 8; response=8'h5A; pass=1; done pulse at cycle 18.
REQ-033 Scenario 2: pattern=8'h3C, expected=8'hFF -> response=8'hC3, pass=0, done pulse once.
REQ-034 Scenario 3: abort in SHIFT_OUT cycle 3 -> IDLE next edge, SE=0, no done; response and pass unchanged from Scenario 2.
REQ-035 Scenario 4: RST=1 during CAPTURE -> all outputs zero at the next edge; a following run with pattern=8'hFF gives response=8'h00 and pass=1 when expected=8'h00.
REQ-036 Scenario 5: start held high continuously -> back-to-back runs separated by exactly one IDLE cycle; start pulses during busy are not counted as extra runs.
